// File: rtl/qracc_sram_arbiter.sv
// Round-robin arbiter sharing the single qrAcc SRAM request port between NUM_REQ requesters.
// Optional read-timeout watchdog is enabled with `define QRACC_ARB_TIMEOUT_EN.
module qracc_sram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int numRows    = 128,
  parameter int numCols    = 32,
  parameter int RD_TIMEOUT = 64,
  localparam int AW = $clog2(numRows),
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              mac_busy_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0]                req_wr_i,
  input  logic [NUM_REQ-1:0][AW-1:0]        req_addr_i,
  input  logic [NUM_REQ-1:0][numCols-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [numCols-1:0]                rsp_data_o,
  output logic                              rsp_err_o,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic                              sram_rq_valid_o,
  output logic                              sram_rq_wr_o,
  output logic [AW-1:0]                     sram_addr_o,
  output logic [numCols-1:0]                sram_wr_data_o,
  input  logic                              sram_rq_ready_i,
  input  logic                              sram_rd_valid_i,
  input  logic [numCols-1:0]                sram_rd_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;

  state_t               r_state, w_state_next;
  logic [IW-1:0]        r_last, w_last_next;
  logic [NUM_REQ-1:0]   r_grant, w_grant_next;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_next;
  logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_next;
  logic [numCols-1:0]   r_rsp_data, w_rsp_data_next;
  logic                 r_rq_valid, w_rq_valid_next;
  logic                 r_rq_wr, w_rq_wr_next;
  logic [AW-1:0]        r_addr, w_addr_next;
  logic [numCols-1:0]   r_wdata, w_wdata_next;
  logic                 w_any;
  logic [IW-1:0]        w_pick;

`ifdef QRACC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic                 r_rsp_err, w_rsp_err_next;
`endif

  // Scan last+1 .. last (wrapping) and take the first valid requester.
  always_comb begin : arb_scan
    int idx;
    w_any  = 1'b0;
    w_pick = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && req_valid_i[idx]) begin
        w_any  = 1'b1;
        w_pick = IW'(idx);
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_last_next      = r_last;
    w_grant_next     = r_grant;
    w_req_ready_next = '0;
    w_rsp_valid_next = '0;
    w_rsp_data_next  = r_rsp_data;
    w_rq_valid_next  = r_rq_valid;
    w_rq_wr_next     = r_rq_wr;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
`ifdef QRACC_ARB_TIMEOUT_EN
    w_cnt_next       = r_cnt;
    w_rsp_err_next   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!mac_busy_i && w_any) begin
          w_state_next         = S_ISSUE;
          w_last_next          = w_pick;
          w_grant_next         = '0;
          w_grant_next[w_pick] = 1'b1;
          w_rq_valid_next      = 1'b1;
          w_rq_wr_next         = req_wr_i[w_pick];
          w_addr_next          = req_addr_i[w_pick];
          w_wdata_next         = req_wdata_i[w_pick];
        end
      end
      S_ISSUE: begin
        if (sram_rq_ready_i) begin
          w_rq_valid_next  = 1'b0;
          w_req_ready_next = r_grant;
          if (r_rq_wr) begin
            w_state_next = S_IDLE;
            w_grant_next = '0;
          end else begin
            w_state_next = S_WAIT_RD;
`ifdef QRACC_ARB_TIMEOUT_EN
            w_cnt_next   = '0;
`endif
          end
        end
      end
      S_WAIT_RD: begin
        if (sram_rd_valid_i) begin
          w_rsp_data_next  = sram_rd_data_i;
          w_rsp_valid_next = r_grant;
          w_grant_next     = '0;
          w_state_next     = S_IDLE;
        end
`ifdef QRACC_ARB_TIMEOUT_EN
        // Compare against RD_TIMEOUT-1 so the registered error pulse lands RD_TIMEOUT cycles after entry.
        else if (r_cnt == CW'(RD_TIMEOUT - 1)) begin
          w_rsp_data_next  = '0;
          w_rsp_valid_next = r_grant;
          w_rsp_err_next   = 1'b1;
          w_grant_next     = '0;
          w_state_next     = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
`endif
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_grant     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rq_valid  <= 1'b0;
      r_rq_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef QRACC_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_last      <= w_last_next;
      r_grant     <= w_grant_next;
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rq_valid  <= w_rq_valid_next;
      r_rq_wr     <= w_rq_wr_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
`ifdef QRACC_ARB_TIMEOUT_EN
      r_cnt       <= w_cnt_next;
      r_rsp_err   <= w_rsp_err_next;
`endif
    end
  end

  assign grant_o         = r_grant;
  assign req_ready_o     = r_req_ready;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_data_o      = r_rsp_data;
  assign sram_rq_valid_o = r_rq_valid;
  assign sram_rq_wr_o    = r_rq_wr;
  assign sram_addr_o     = r_addr;
  assign sram_wr_data_o  = r_wdata;
`ifdef QRACC_ARB_TIMEOUT_EN
  assign rsp_err_o       = r_rsp_err;
`else
  assign rsp_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed self-checking bench for qracc_sram_arbiter; the timeout scenario runs only
// when QRACC_ARB_TIMEOUT_EN is defined.
module tb_qracc_sram_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ROWS    = 128;
  localparam int COLS    = 32;
  localparam int AW      = 7;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic                           mac_busy;
  logic [NUM_REQ-1:0]             req_valid, req_wr;
  logic [NUM_REQ-1:0][AW-1:0]     req_addr;
  logic [NUM_REQ-1:0][COLS-1:0]   req_wdata;
  logic [NUM_REQ-1:0]             req_ready_o, rsp_valid_o, grant_o;
  logic [COLS-1:0]                rsp_data_o;
  logic                           rsp_err_o;
  logic                           sram_rq_valid_o, sram_rq_wr_o;
  logic [AW-1:0]                  sram_addr_o;
  logic [COLS-1:0]                sram_wr_data_o;
  logic                           sram_rq_ready, sram_rd_valid;
  logic [COLS-1:0]                sram_rd_data;

  int checks   = 0;
  int failures = 0;

  qracc_sram_arbiter #(.NUM_REQ(NUM_REQ), .numRows(ROWS), .numCols(COLS), .RD_TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst), .mac_busy_i(mac_busy),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .grant_o(grant_o), .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o),
    .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o),
    .sram_rq_ready_i(sram_rq_ready), .sram_rd_valid_i(sram_rd_valid), .sram_rd_data_i(sram_rd_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) tick;
    checks++;
    if ({grant_o, req_ready_o, rsp_valid_o, rsp_err_o, sram_rq_valid_o, sram_rq_wr_o} !== 10'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0", {grant_o, req_ready_o, rsp_valid_o, rsp_err_o, sram_rq_valid_o, sram_rq_wr_o});
    end
    checks++;
    if ({sram_addr_o, sram_wr_data_o, rsp_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr %0d wdata %h rdata %h want 0", sram_addr_o, sram_wr_data_o, rsp_data_o);
    end
    nrst = 1'b1;
    tick;
  endtask

  task automatic test_single_write;
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 7'd5; req_wdata[0] = 32'hA5A5A5A5;
    tick;
    checks++;
    if ({sram_rq_valid_o, sram_rq_wr_o, grant_o} !== 4'b1101) begin
      failures++; $display("FAIL wr_issue: got valid/wr/grant %b want 1101", {sram_rq_valid_o, sram_rq_wr_o, grant_o});
    end
    checks++;
    if (sram_addr_o !== 7'd5 || sram_wr_data_o !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL wr_fields: got addr %0d data %h want 5 a5a5a5a5", sram_addr_o, sram_wr_data_o);
    end
    tick;
    checks++;
    if (sram_rq_valid_o !== 1'b1 || req_ready_o !== 2'b00 || sram_addr_o !== 7'd5) begin
      failures++; $display("FAIL wr_hold: got valid %b ready %b addr %0d want 1 00 5", sram_rq_valid_o, req_ready_o, sram_addr_o);
    end
    sram_rq_ready = 1'b1;
    tick;
    checks++;
    if (req_ready_o !== 2'b01 || sram_rq_valid_o !== 1'b0 || grant_o !== 2'b00) begin
      failures++; $display("FAIL wr_done: got ready %b valid %b grant %b want 01 0 00", req_ready_o, sram_rq_valid_o, grant_o);
    end
    req_valid[0] = 1'b0;
    sram_rq_ready = 1'b0;
    tick;
    checks++;
    if (req_ready_o !== 2'b00 || grant_o !== 2'b00 || sram_rq_valid_o !== 1'b0) begin
      failures++; $display("FAIL wr_idle: got ready %b grant %b valid %b want 00 00 0", req_ready_o, grant_o, sram_rq_valid_o);
    end
    $display("txn write req0 addr 5 data a5a5a5a5");
  endtask

  task automatic test_read_routing;
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 7'd5;
    tick;
    checks++;
    if (grant_o !== 2'b10 || sram_rq_valid_o !== 1'b1 || sram_rq_wr_o !== 1'b0 || sram_addr_o !== 7'd5) begin
      failures++; $display("FAIL rd_issue: got grant %b valid %b wr %b addr %0d want 10 1 0 5", grant_o, sram_rq_valid_o, sram_rq_wr_o, sram_addr_o);
    end
    sram_rq_ready = 1'b1;
    tick;
    checks++;
    if (req_ready_o !== 2'b10 || grant_o !== 2'b10 || sram_rq_valid_o !== 1'b0) begin
      failures++; $display("FAIL rd_accept: got ready %b grant %b valid %b want 10 10 0", req_ready_o, grant_o, sram_rq_valid_o);
    end
    req_valid[1] = 1'b0;
    sram_rq_ready = 1'b0;
    tick;
    checks++;
    if (rsp_valid_o !== 2'b00) begin
      failures++; $display("FAIL rd_wait: got rsp_valid %b want 00", rsp_valid_o);
    end
    sram_rd_valid = 1'b1; sram_rd_data = 32'hA5A5A5A5;
    tick;
    checks++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== 32'hA5A5A5A5 || rsp_err_o !== 1'b0 || grant_o !== 2'b00) begin
      failures++; $display("FAIL rd_rsp: got valid %b data %h err %b grant %b want 10 a5a5a5a5 0 00", rsp_valid_o, rsp_data_o, rsp_err_o, grant_o);
    end
    // rd_valid still high while back in IDLE must be ignored
    sram_rd_data = 32'h0BAD0BAD;
    tick;
    checks++;
    if (rsp_valid_o !== 2'b00) begin
      failures++; $display("FAIL rd_stray: got rsp_valid %b want 00", rsp_valid_o);
    end
    sram_rd_valid = 1'b0;
    tick;
    checks++;
    if (rsp_valid_o !== 2'b00 || rsp_data_o !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL rd_after: got valid %b data %h want 00 a5a5a5a5", rsp_valid_o, rsp_data_o);
    end
    $display("txn read req1 addr 5 data a5a5a5a5");
  endtask

  task automatic test_round_robin;
    int cnt [2];
    int order [$];
    cnt[0] = 0; cnt[1] = 0;
    req_valid = 2'b11; req_wr = 2'b11;
    req_addr[0] = 7'd10; req_addr[1] = 7'd20;
    req_wdata[0] = 32'h100; req_wdata[1] = 32'h200;
    sram_rq_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && order.size() < 8; cyc++) begin
      tick;
      if (req_ready_o != 2'b00) begin
        int r;
        r = req_ready_o[1] ? 1 : 0;
        checks++;
        if (req_ready_o === 2'b11) begin
          failures++; $display("FAIL rr_onehot: got ready %b want one-hot", req_ready_o);
        end
        checks++;
        if (sram_addr_o !== 7'(10 + 10 * r + cnt[r]) || sram_wr_data_o !== 32'(32'h100 * (r + 1) + cnt[r])) begin
          failures++; $display("FAIL rr_fields: got addr %0d data %h want %0d %h", sram_addr_o, sram_wr_data_o, 10 + 10 * r + cnt[r], 32'h100 * (r + 1) + cnt[r]);
        end
        $display("txn rr %0d write req%0d addr %0d", order.size(), r, sram_addr_o);
        order.push_back(r);
        cnt[r]++;
        if (cnt[r] == 4) begin
          req_valid[r] = 1'b0;
        end else begin
          req_addr[r]  = 7'(10 + 10 * r + cnt[r]);
          req_wdata[r] = 32'(32'h100 * (r + 1) + cnt[r]);
        end
      end
    end
    sram_rq_ready = 1'b0;
    req_valid = 2'b00;
    checks++;
    if (order.size() != 8) begin
      failures++; $display("FAIL rr_count: got %0d grants want 8", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] != i % 2) begin
        failures++; $display("FAIL rr_order: grant %0d got req%0d want req%0d", i, order[i], i % 2);
      end
    end
    tick;
  endtask

  task automatic test_mac_gating;
    mac_busy = 1'b1;
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 7'd7; req_wdata[0] = 32'h77;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (sram_rq_valid_o !== 1'b0 || grant_o !== 2'b00) begin
        failures++; $display("FAIL mac_block: cycle %0d got valid %b grant %b want 0 00", i, sram_rq_valid_o, grant_o);
      end
    end
    mac_busy = 1'b0;
    tick;
    checks++;
    if (sram_rq_valid_o !== 1'b1 || grant_o !== 2'b01 || sram_addr_o !== 7'd7) begin
      failures++; $display("FAIL mac_release: got valid %b grant %b addr %0d want 1 01 7", sram_rq_valid_o, grant_o, sram_addr_o);
    end
    mac_busy = 1'b1;
    sram_rq_ready = 1'b1;
    tick;
    checks++;
    if (req_ready_o !== 2'b01 || sram_rq_valid_o !== 1'b0) begin
      failures++; $display("FAIL mac_complete: got ready %b valid %b want 01 0", req_ready_o, sram_rq_valid_o);
    end
    req_valid[0] = 1'b0;
    sram_rq_ready = 1'b0;
    mac_busy = 1'b0;
    tick;
    $display("txn write req0 addr 7 under mac_busy");
  endtask

  task automatic test_reset_wait_rd;
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 7'd5;
    tick;
    sram_rq_ready = 1'b1;
    tick;
    req_valid[0] = 1'b0;
    sram_rq_ready = 1'b0;
    tick;
    nrst = 1'b0;
    #1;
    checks++;
    if ({grant_o, req_ready_o, rsp_valid_o, rsp_err_o, sram_rq_valid_o, sram_rq_wr_o} !== 10'd0 || rsp_data_o !== '0) begin
      failures++; $display("FAIL rst_rd_outputs: got ctrl %b data %h want 0", {grant_o, req_ready_o, rsp_valid_o, rsp_err_o, sram_rq_valid_o, sram_rq_wr_o}, rsp_data_o);
    end
    sram_rd_valid = 1'b1; sram_rd_data = 32'h12345678;
    tick;
    nrst = 1'b1;
    sram_rd_valid = 1'b0;
    tick;
    checks++;
    if (rsp_valid_o !== 2'b00 || rsp_data_o !== '0) begin
      failures++; $display("FAIL rst_rd_norsp: got valid %b data %h want 00 0", rsp_valid_o, rsp_data_o);
    end
    req_valid = 2'b11; req_wr = 2'b11;
    req_addr[0] = 7'd30; req_addr[1] = 7'd31;
    tick;
    checks++;
    if (grant_o !== 2'b01 || sram_addr_o !== 7'd30) begin
      failures++; $display("FAIL rst_rd_regrant: got grant %b addr %0d want 01 30", grant_o, sram_addr_o);
    end
    sram_rq_ready = 1'b1;
    tick;
    req_valid[0] = 1'b0;
    tick;
    tick;
    req_valid[1] = 1'b0;
    sram_rq_ready = 1'b0;
    tick;
    $display("txn read req0 abandoned by reset, then writes req0 addr 30 / req1 addr 31");
  endtask

`ifdef QRACC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_addr[1] = 7'd9;
    tick;
    sram_rq_ready = 1'b1;
    tick;
    req_valid[1] = 1'b0;
    sram_rq_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++;
      if (k < 8 && (rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0)) begin
        failures++; $display("FAIL to_early: cycle %0d got valid %b err %b want 00 0", k, rsp_valid_o, rsp_err_o);
      end else if (k == 8 && (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1 || rsp_data_o !== '0 || grant_o !== 2'b00)) begin
        failures++; $display("FAIL to_pulse: got valid %b err %b data %h grant %b want 10 1 0 00", rsp_valid_o, rsp_err_o, rsp_data_o, grant_o);
      end
    end
    tick;
    checks++;
    if (rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0) begin
      failures++; $display("FAIL to_after: got valid %b err %b want 00 0", rsp_valid_o, rsp_err_o);
    end
    $display("txn read req1 addr 9 timed out");
  endtask
`endif

  initial begin
    nrst = 1'b0; mac_busy = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    sram_rq_ready = 1'b0; sram_rd_valid = 1'b0; sram_rd_data = '0;
    test_reset;
    test_single_write;
    test_read_routing;
    test_round_robin;
    test_mac_gating;
    test_reset_wait_rd;
`ifdef QRACC_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
